// File: rtl/radar_scan.sv
// Radar sweep sequencer: walks a 3-bit LED position up and down (or round and
// round) at a programmable rate, driving an active-low one-hot LED decoder.
module radar_scan #(
  parameter int DIV = 1_350_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       mode,
  input  logic [1:0] speed,
  output logic [2:0] pos,
  output logic       en,
  output logic       dir,
  output logic       step
);

  // One spare bit beyond 4*DIV so the slowest period never overflows.
  localparam int CW = $clog2(4 * DIV) + 1;

  typedef enum logic [1:0] {IDLE, FWD, REV} state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [1:0]    spd_reg, spd_next;
  logic [2:0]    pos_next;
  logic          en_next, dir_next, step_next;
  logic [CW-1:0] last_cnt;
  logic          tick;

  assign last_cnt = CW'(DIV) * (CW'(spd_reg) + CW'(1)) - CW'(1);
  assign tick     = (state_reg != IDLE) && (cnt_reg == last_cnt);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      spd_reg   <= '0;
      pos       <= '0;
      en        <= 1'b0;
      dir       <= 1'b0;
      step      <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      spd_reg   <= spd_next;
      pos       <= pos_next;
      en        <= en_next;
      dir       <= dir_next;
      step      <= step_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    spd_next   = spd_reg;
    pos_next   = pos;
    en_next    = en;
    dir_next   = dir;
    step_next  = 1'b0;
    unique case (state_reg)
      IDLE: begin
        cnt_next = '0;
        en_next  = 1'b0;
        pos_next = '0;
        dir_next = 1'b0;
        // stop wins over a simultaneous start
        if (start && !stop) begin
          state_next = FWD;
          en_next    = 1'b1;
          spd_next   = speed;
        end
      end
      FWD, REV: begin
        if (stop) begin
          state_next = IDLE;
          cnt_next   = '0;
          en_next    = 1'b0;
          pos_next   = '0;
          dir_next   = 1'b0;
        end else if (tick) begin
          cnt_next  = '0;
          spd_next  = speed;
          step_next = 1'b1;
          if (state_reg == FWD) begin
            if (pos != 3'd7) begin
              pos_next = pos + 3'd1;
            end else if (mode) begin
              pos_next = 3'd0;
            end else begin
              state_next = REV;
              pos_next   = 3'd6;
              dir_next   = 1'b1;
            end
          end else begin
            // Leaving REV always resumes ascending; wrap mode steps up from here.
            if (mode) begin
              state_next = FWD;
              pos_next   = pos + 3'd1;
              dir_next   = 1'b0;
            end else if (pos != 3'd0) begin
              pos_next = pos - 3'd1;
            end else begin
              state_next = FWD;
              pos_next   = 3'd1;
              dir_next   = 1'b0;
            end
          end
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule
